// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters gated by an IDLE/RUN/DRAIN controller.
// Every output is registered one clock after the counter state it describes.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
    localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);
    localparam logic [11:0] HAct     = 12'(H_ACTIVE);
    localparam logic [11:0] VAct     = 12'(V_ACTIVE);
    localparam logic [11:0] HsStart  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HsEnd    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VsStart  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VsEnd    = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        running;
    logic        frame_end;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        ls_q, ls_d;
    logic        fs_q, fs_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        busy_q, busy_d;

    assign running   = (state_q != StIdle);
    assign frame_end = (h_cnt_q == HLast) && (v_cnt_q == VLast);

    // en only decides the fate of the frame boundary; the frame in flight always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = frame_end ? StIdle : StDrain;
            StDrain: begin
                if (en) begin
                    state_d = StRun;
                end else if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (running) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    always_comb begin
        de_d        = running && (h_cnt_q < HAct) && (v_cnt_q < VAct);
        hs_d        = (running && (h_cnt_q >= HsStart) && (h_cnt_q < HsEnd)) ? HS_POL : ~HS_POL;
        vs_d        = (running && (v_cnt_q >= VsStart) && (v_cnt_q < VsEnd)) ? VS_POL : ~VS_POL;
        x_d         = de_d ? h_cnt_q : 12'd0;
        y_d         = de_d ? v_cnt_q : 12'd0;
        ls_d        = de_d && (h_cnt_q == 12'd0);
        fs_d        = de_d && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        frame_cnt_d = fs_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
        busy_d      = running;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            ls_q        <= 1'b0;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ls_q        <= ls_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign de_out      = de_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a linear pixel-index model predicts every output clock;
// a monitor pops and compares. Timing is scaled down so full frames fit a short run.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 4, HSW = 6, HBP = 5;
    localparam int VA = 12, VFP = 2, VSW = 3, VBP = 4;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        hs_out, vs_out, de_out, line_start, frame_start, busy;
    logic [11:0] x_out, y_out;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .x_out(x_out), .y_out(y_out),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Model: pos is the frame-linear index of the pixel being generated, -1 when stopped.
    int pos = -1;
    logic [15:0] m_fc = 16'h0;

    task automatic step(input logic r, input logic e);
        exp_t x;
        int h;
        int v;
        rst = r;
        en  = e;
        x.hs = ~HP; x.vs = ~VP; x.de = 1'b0; x.x = '0; x.y = '0;
        x.ls = 1'b0; x.fs = 1'b0; x.busy = 1'b0;
        if (r) begin
            pos  = -1;
            m_fc = 16'h0;
        end else begin
            if (pos >= 0) begin
                h = pos % HT;
                v = pos / HT;
                x.busy = 1'b1;
                x.de = (h < HA) && (v < VA);
                if (x.de) begin
                    x.x = 12'(h);
                    x.y = 12'(v);
                end
                x.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
                x.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
                x.ls = x.de && (h == 0);
                x.fs = (pos == 0);
                if (x.fs) m_fc = m_fc + 16'h1;
            end
            // en at the last pixel of a frame (or while stopped) decides whether a frame follows.
            if (pos == -1 || pos == FRAME - 1) pos = e ? 0 : -1;
            else pos = pos + 1;
        end
        x.fc = m_fc;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic wait_pos(input int target, input logic e);
        int n;
        n = 0;
        while (pos != target && n < 2 * FRAME + 4) begin
            step(1'b0, e);
            n++;
        end
        if (pos != target) begin
            failures++;
            $display("FAIL wait_pos: model position %0d, required %0d", pos, target);
        end
    endtask

    // Monitor: one comparison per clock, plus frame-period check for uninterrupted runs.
    initial begin
        exp_t e;
        exp_t a;
        int cyc;
        int last_fs;
        bit have_fs;
        bit gap;
        cyc = 0; last_fs = 0; have_fs = 0; gap = 1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hs_out, vs_out, de_out, x_out, y_out, line_start, frame_start, frame_cnt, busy};
                cyc++;
                checks++;
                if (a !== e) begin
                    failures++;
                    if (failures <= 20)
                        $display("FAIL outputs cyc=%0d actual hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%h busy=%b required hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%h busy=%b",
                                 cyc, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.fc, a.busy,
                                 e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.fc, e.busy);
                end
                if (!busy) gap = 1;
                if (frame_start) begin
                    if (have_fs && !gap) begin
                        checks++;
                        if (cyc - last_fs != FRAME) begin
                            failures++;
                            $display("FAIL fs_period: actual %0d clocks, required %0d", cyc - last_fs, FRAME);
                        end
                    end
                    have_fs = 1;
                    last_fs = cyc;
                    gap = 0;
                end
            end
        end
    end

    initial begin
        logic en_r;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);

        // Three back-to-back frames with en held high.
        repeat (3 * FRAME + 5) step(1'b0, 1'b1);

        // en dropped at line 4: the frame drains to its end and the block goes idle.
        wait_pos(4 * HT, 1'b1);
        wait_pos(-1, 1'b0);
        repeat (5) step(1'b0, 1'b0);

        // en dropped at line 4, re-raised at line 10: next frame follows with no gap.
        step(1'b0, 1'b1);
        wait_pos(4 * HT, 1'b1);
        wait_pos(10 * HT, 1'b0);
        wait_pos(5, 1'b1);

        // Reset mid-frame at the centre pixel, then a fresh start.
        wait_pos((VA / 2) * HT + HA / 2, 1'b1);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        wait_pos(2 * HT, 1'b1);

        // frame_cnt wrap from 0xFFFF on the next frame start.
        wait_pos(-1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        force dut.frame_cnt_q = 16'hFFFF;
        m_fc = 16'hFFFF;
        step(1'b0, 1'b0);
        release dut.frame_cnt_q;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (frame_start !== 1'b1 || frame_cnt !== 16'h0000) begin
            failures++;
            $display("FAIL fc_wrap: actual fs=%b fc=%h, required fs=1 fc=0000", frame_start, frame_cnt);
        end

        // Randomised en toggling with occasional resets.
        en_r = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 99) < 3) en_r = ~en_r;
            step(($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0, en_r);
        end
        wait_pos(-1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        @(posedge clk);
        #2;

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: actual %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the following parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- HS_POL, 0, asserted level of hs_out.
- VS_POL, 0, asserted level of vs_out.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, run request; sampled at frame boundaries only.
- hs_out, out, 1, horizontal sync at HS_POL level when asserted.
- vs_out, out, 1, vertical sync at VS_POL level when asserted.
- de_out, out, 1, active-pixel strobe.
- x_out, out, 12, pixel column; 0 outside the active region.
- y_out, out, 12, pixel row; 0 outside the active region.
- line_start, out, 1, one-clock pulse on the first active pixel of each active line.
- frame_start, out, 1, one-clock pulse coincident with pixel (0,0).
- frame_cnt, out, 16, count of frames started; wraps modulo 2^16.
- busy, out, 1, high while not IDLE.

Function
REQ-004 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-005 Internal h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment on h_cnt wrap, count 0..V_TOTAL-1, and wrap to 0.
REQ-006 Line layout SHALL be, in order: active (h_cnt < H_ACTIVE), front porch, sync, back porch; frame layout SHALL follow the same order in lines.
REQ-007 hs_out SHALL be asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs_out SHALL be asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-008 de_out SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; in that case x_out=h_cnt and y_out=v_cnt, otherwise both SHALL be 0.
REQ-009 All outputs SHALL be registered with exactly one clock of latency from the counter state, and hs_out, vs_out, de_out, x_out and y_out SHALL stay mutually aligned.
REQ-010 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-011 IDLE -> RUN SHALL occur when en=1; counters start at (0,0) on the next clock, and frame_start pulses together with the first de_out.
REQ-012 RUN -> DRAIN SHALL occur when en=0 is sampled mid-frame; the current frame then completes unchanged.
REQ-013 DRAIN -> IDLE SHALL occur at the last pixel of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
REQ-014 DRAIN -> RUN SHALL occur if en returns to 1 before the frame ends, with no gap and no restart.
REQ-015 In RUN, en=1 at the frame end SHALL continue into the next frame seamlessly: counters wrap to (0,0) with no idle clock.
REQ-016 In IDLE, outputs SHALL be: hs_out=~HS_POL, vs_out=~VS_POL, de_out=0, x_out=0, y_out=0, line_start=0, frame_start=0, busy=0; counters SHALL hold at 0.
REQ-017 frame_cnt SHALL increment by 1 in the same clock that frame_start is asserted, wrapping 0xFFFF -> 0x0000.
REQ-018 en toggling within a frame SHALL never truncate or stretch any line or frame.

Reset
REQ-019 rst=1 SHALL override everything at the next clock edge: state IDLE, counters 0, frame_cnt=0, and all outputs at their REQ-016 values.
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately with no drain, and a later en=1 SHALL start a fresh frame at (0,0).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- rst then en=1 held, defaults: de_out high for 640 clocks per line, 480 lines; hs_out low for 96 clocks beginning 656 clocks after the line's first de; period 800 clocks; vs_out low for 2 lines starting at line 490; frame period 420000 clocks.
- en=1 for 3 frames: frame_start pulses exactly at clocks 0, 420000 and 840000 relative to the first; frame_cnt reads 1, 2, 3; x_out/y_out reach (639,479) once per frame.
- en dropped at line 100: the frame completes to v_cnt=524/h_cnt=799, busy falls the next clock, and no further de_out occurs.
- en dropped at line 100 and re-raised at line 300: no gap occurs; the next frame_start arrives exactly 420000 clocks after the previous one.
- rst pulsed at pixel (320,240): the outputs go to IDLE values on the next clock and frame_cnt=0; en=1 then gives frame_start with x_out=0, y_out=0.
- frame_cnt preloaded by forcing to 0xFFFF, then a frame start: frame_cnt reads 0x0000.
